// File: rtl/signal_aspect_pkg.sv
// Shared types for the signal aspect monitor: aspect encoding, fault codes, FSM states.
package signal_aspect_pkg;

  typedef enum logic [1:0] {ASP_R, ASP_Y, ASP_G, ASP_BAD} aspect_e;

  typedef enum logic [1:0] {ST_STARTUP, ST_MONITOR, ST_FAULT} state_e;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_CONFLICT  = 3'd1;
  localparam logic [2:0] FC_ILLEGAL   = 3'd2;
  localparam logic [2:0] FC_SEQ       = 3'd3;
  localparam logic [2:0] FC_SHORT_YLW = 3'd4;
  localparam logic [2:0] FC_STUCK     = 3'd5;

  // Exactly one lamp lit is a legal aspect; anything else is ASP_BAD.
  function automatic aspect_e encode_aspect(input logic g, input logic y, input logic r);
    aspect_e a;
    case ({g, y, r})
      3'b100:  a = ASP_G;
      3'b010:  a = ASP_Y;
      3'b001:  a = ASP_R;
      default: a = ASP_BAD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/signal_aspect_monitor_tracker.sv
// Per-direction aspect tracker: previous aspect, saturating dwell counter and
// the per-direction fault flags evaluated against the registered inputs.
module aspect_tracker
  import signal_aspect_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MIN_YLW   = 3,
  parameter int MAX_DWELL = 255
) (
  input  logic ck,
  input  logic clr,
  input  logic g,
  input  logic y,
  input  logic r,
  output logic bad,
  output logic seq_err,
  output logic short_ylw,
  output logic stuck,
  output logic not_red
);

  aspect_e            cur, prev;
  logic [CNT_W-1:0]   dwell;
  logic               changed;
  logic               legal_step;

  assign cur     = encode_aspect(g, y, r);
  assign changed = (cur != prev);

  // Coming out of a bad aspect is not a sequence error; ILLEGAL already covers it.
  always_comb begin
    legal_step = 1'b1;
    case (prev)
      ASP_G:   legal_step = (cur == ASP_Y);
      ASP_Y:   legal_step = (cur == ASP_R);
      ASP_R:   legal_step = (cur == ASP_G);
      default: legal_step = 1'b1;
    endcase
  end

  assign bad       = (cur == ASP_BAD);
  assign seq_err   = changed && !bad && !legal_step;
  assign short_ylw = (prev == ASP_Y) && (cur == ASP_R) && (dwell < CNT_W'(MIN_YLW));
  assign stuck     = !changed && (dwell == CNT_W'(MAX_DWELL));
  assign not_red   = (cur != ASP_R);

  always_ff @(posedge ck) begin
    if (clr) begin
      prev  <= ASP_R;
      dwell <= '0;
    end else begin
      prev <= cur;
      if (changed)
        dwell <= CNT_W'(1);
      else if (dwell != CNT_W'(MAX_DWELL))
        dwell <= dwell + 1'b1;
    end
  end

endmodule

// File: rtl/signal_aspect_monitor.sv
// Safety monitor between the traffic-light controller and the lamp drivers:
// passes legal aspects through, latches the first fault and flashes red after it.
module signal_aspect_monitor
  import signal_aspect_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int MIN_YLW        = 3,
  parameter int MAX_DWELL      = 255,
  parameter int STARTUP_CYCLES = 16,
  parameter int FLASH_HALF     = 8
) (
  input  logic       CK,
  input  logic       CLR,
  input  logic       GRN1,
  input  logic       YLW1,
  input  logic       RED1,
  input  logic       GRN2,
  input  logic       YLW2,
  input  logic       RED2,
  output logic       LAMP_G1,
  output logic       LAMP_Y1,
  output logic       LAMP_R1,
  output logic       LAMP_G2,
  output logic       LAMP_Y2,
  output logic       LAMP_R2,
  output logic       FAULT,
  output logic [2:0] FAULT_CODE
);

  // Index 0 is direction 1, index 1 is direction 2.
  logic [1:0]       s_g, s_y, s_r;
  logic [1:0]       lamp_g, lamp_y, lamp_r;
  logic [1:0]       bad, seq_err, short_ylw, stuck, not_red;
  logic [CNT_W-1:0] start_cnt, flash_cnt;
  logic [2:0]       code;
  state_e           state, state_nxt;

  for (genvar d = 0; d < 2; d++) begin : g_dir
    aspect_tracker #(
      .CNT_W    (CNT_W),
      .MIN_YLW  (MIN_YLW),
      .MAX_DWELL(MAX_DWELL)
    ) u_trk (
      .ck       (CK),
      .clr      (CLR),
      .g        (s_g[d]),
      .y        (s_y[d]),
      .r        (s_r[d]),
      .bad      (bad[d]),
      .seq_err  (seq_err[d]),
      .short_ylw(short_ylw[d]),
      .stuck    (stuck[d]),
      .not_red  (not_red[d])
    );
  end

  // Lowest code wins when several conditions hold at once.
  always_comb begin
    code = FC_NONE;
    if (&not_red)        code = FC_CONFLICT;
    else if (|bad)       code = FC_ILLEGAL;
    else if (|seq_err)   code = FC_SEQ;
    else if (|short_ylw) code = FC_SHORT_YLW;
    else if (|stuck)     code = FC_STUCK;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_STARTUP: if (start_cnt == CNT_W'(STARTUP_CYCLES - 1)) state_nxt = ST_MONITOR;
      ST_MONITOR: if (code != FC_NONE) state_nxt = ST_FAULT;
      default:    state_nxt = ST_FAULT;
    endcase
  end

  always_ff @(posedge CK) begin
    if (CLR) begin
      state      <= ST_STARTUP;
      s_g        <= '0;
      s_y        <= '0;
      s_r        <= 2'b11;
      lamp_g     <= '0;
      lamp_y     <= '0;
      lamp_r     <= 2'b11;
      start_cnt  <= '0;
      flash_cnt  <= '0;
      FAULT      <= 1'b0;
      FAULT_CODE <= FC_NONE;
    end else begin
      state <= state_nxt;
      s_g   <= {GRN2, GRN1};
      s_y   <= {YLW2, YLW1};
      s_r   <= {RED2, RED1};
      case (state)
        ST_STARTUP: begin
          start_cnt <= start_cnt + 1'b1;
          lamp_g    <= s_g;
          lamp_y    <= s_y;
          lamp_r    <= s_r;
        end
        ST_MONITOR: begin
          if (code != FC_NONE) begin
            FAULT      <= 1'b1;
            FAULT_CODE <= code;
            lamp_g     <= '0;
            lamp_y     <= '0;
            lamp_r     <= 2'b11;
            flash_cnt  <= '0;
          end else begin
            lamp_g <= s_g;
            lamp_y <= s_y;
            lamp_r <= s_r;
          end
        end
        default: begin
          // Both reds flash in phase; code and flag stay frozen until CLR.
          if (flash_cnt == CNT_W'(FLASH_HALF - 1)) begin
            flash_cnt <= '0;
            lamp_r    <= {2{~lamp_r[0]}};
          end else begin
            flash_cnt <= flash_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign LAMP_G1 = lamp_g[0];
  assign LAMP_Y1 = lamp_y[0];
  assign LAMP_R1 = lamp_r[0];
  assign LAMP_G2 = lamp_g[1];
  assign LAMP_Y2 = lamp_y[1];
  assign LAMP_R2 = lamp_r[1];

endmodule

// File: tb/tb_signal_aspect_monitor.sv
// Directed bench for signal_aspect_monitor: scoreboard of expected lamp outputs
// (2-cycle pass-through) plus directed fault, flash and reset checks.
module tb_signal_aspect_monitor;

  localparam logic [2:0] A_G = 3'b100;
  localparam logic [2:0] A_Y = 3'b010;
  localparam logic [2:0] A_R = 3'b001;
  localparam logic [5:0] ALL_RED = 6'b001001;

  logic       CK = 1'b0;
  logic       CLR = 1'b1;
  logic [5:0] pins = ALL_RED;   // {G1,Y1,R1,G2,Y2,R2}
  logic       GRN1, YLW1, RED1, GRN2, YLW2, RED2;
  logic       LAMP_G1, LAMP_Y1, LAMP_R1, LAMP_G2, LAMP_Y2, LAMP_R2;
  logic       FAULT;
  logic [2:0] FAULT_CODE;
  logic [5:0] lamps;

  assign {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = pins;
  assign lamps = {LAMP_G1, LAMP_Y1, LAMP_R1, LAMP_G2, LAMP_Y2, LAMP_R2};

  typedef struct packed {
    logic       chk;
    logic [5:0] lamps;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 CK = ~CK;

  signal_aspect_monitor dut (
    .CK(CK), .CLR(CLR),
    .GRN1(GRN1), .YLW1(YLW1), .RED1(RED1),
    .GRN2(GRN2), .YLW2(YLW2), .RED2(RED2),
    .LAMP_G1(LAMP_G1), .LAMP_Y1(LAMP_Y1), .LAMP_R1(LAMP_R1),
    .LAMP_G2(LAMP_G2), .LAMP_Y2(LAMP_Y2), .LAMP_R2(LAMP_R2),
    .FAULT(FAULT), .FAULT_CODE(FAULT_CODE)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_entry(input exp_t e);
    if (e.chk) begin
      chk("pass_lamps", 8'(lamps), 8'(e.lamps));
      chk("pass_fault", {4'd0, FAULT, FAULT_CODE}, 8'd0);
    end
  endtask

  // Drive one cycle of pins; the output for them is compared two edges later.
  task automatic step(input logic [5:0] p, input logic c);
    pins = p;
    sb_q.push_back('{chk: c, lamps: p});
    @(posedge CK); #1;
    if (sb_q.size() == 2) cmp_entry(sb_q.pop_front());
  endtask

  task automatic steps(input logic [5:0] p, input int n);
    for (int i = 0; i < n; i++) step(p, 1'b1);
  endtask

  task automatic drain();
    while (sb_q.size() > 0) begin
      @(posedge CK); #1;
      cmp_entry(sb_q.pop_front());
    end
  endtask

  task automatic do_reset(input string tag);
    CLR  = 1'b1;
    pins = ALL_RED;
    @(posedge CK); #1;
    chk({tag, "_rst_lamps"}, 8'(lamps), 8'(ALL_RED));
    chk({tag, "_rst_fault"}, 8'(FAULT), 8'd0);
    chk({tag, "_rst_code"},  8'(FAULT_CODE), 8'd0);
    CLR = 1'b0;
    sb_q.delete();
  endtask

  // Called right after the offending pins were clocked in.
  task automatic expect_fault(input string tag, input logic [2:0] code);
    sb_q.delete();
    chk({tag, "_latency"}, 8'(FAULT), 8'd0);
    @(posedge CK); #1;
    chk({tag, "_flag"},  8'(FAULT), 8'd1);
    chk({tag, "_code"},  8'(FAULT_CODE), 8'(code));
    chk({tag, "_lamps"}, 8'(lamps), 8'(ALL_RED));
  endtask

  initial begin
    // Legal full cycle, startup then monitor, no fault.
    do_reset("t1");
    steps({A_R, A_G}, 20);
    steps({A_R, A_Y}, 3);
    steps({A_G, A_R}, 10);
    steps({A_Y, A_R}, 3);
    steps({A_R, A_G}, 10);
    steps({A_R, A_Y}, 3);
    steps({A_R, A_R}, 2);
    drain();
    chk("t1_no_fault", 8'(FAULT), 8'd0);

    // Conflict for one cycle, then flash timing and frozen code.
    do_reset("t2");
    steps(ALL_RED, 18);
    step({A_G, A_G}, 1'b0);
    pins = ALL_RED;
    expect_fault("t2", 3'd1);
    pins = {A_G, A_Y};
    repeat (7) @(posedge CK); #1;
    chk("t2_flash_e7", 8'(lamps), 8'(ALL_RED));
    @(posedge CK); #1;
    chk("t2_flash_e8", 8'(lamps), 8'd0);
    repeat (7) @(posedge CK); #1;
    chk("t2_flash_e15", 8'(lamps), 8'd0);
    @(posedge CK); #1;
    chk("t2_flash_e16", 8'(lamps), 8'(ALL_RED));
    chk("t2_code_frozen", 8'(FAULT_CODE), 8'd1);

    // Yellow held 2 cycles.
    do_reset("t3a");
    steps(ALL_RED, 18);
    steps({A_G, A_R}, 5);
    steps({A_Y, A_R}, 2);
    step(ALL_RED, 1'b0);
    expect_fault("t3a", 3'd4);

    // Green straight to red.
    do_reset("t3b");
    steps(ALL_RED, 18);
    steps({A_G, A_R}, 5);
    step(ALL_RED, 1'b0);
    expect_fault("t3b", 3'd3);

    // Conflict and illegal together: conflict wins.
    do_reset("t4");
    steps(ALL_RED, 18);
    step({3'b110, A_G}, 1'b0);
    expect_fault("t4", 3'd1);

    // Illegal aspects masked during startup, then stuck red.
    do_reset("t5");
    steps({3'b000, 3'b111}, 12);
    step(ALL_RED, 1'b1);
    drain();
    repeat (254) @(posedge CK); #1;
    chk("t5_not_yet_stuck", 8'(FAULT), 8'd0);
    @(posedge CK); #1;
    chk("t5_flag", 8'(FAULT), 8'd1);
    chk("t5_code", 8'(FAULT_CODE), 8'd5);

    // CLR from FAULT while the reds are dark.
    repeat (8) @(posedge CK); #1;
    chk("t6_dark", 8'(lamps), 8'd0);
    do_reset("t6");
    steps({3'b011, 3'b000}, 6);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
